// File: rtl/wishbone_dma_if.sv
// Wishbone classic bus bundle shared by the DMA master and the memory slave it copies through.
interface wishbone_interface;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_mosi;
   logic        ack;
   logic        err;
   logic [31:0] dat_miso;

   modport master (
      output cyc, stb, we, adr, sel, dat_mosi,
      input  ack, err, dat_miso
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_mosi,
      output ack, err, dat_miso
   );
endinterface

// File: rtl/wishbone_dma.sv
// Word-by-word memory-to-memory copy engine: one read then one write per word over a Wishbone master,
// aborting on bus error or when the slave stays silent for TIMEOUT wait cycles.
module wishbone_dma #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic        error,
   wishbone_interface.master m
);

   localparam int unsigned   CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT
   } state_t;

   state_t        state_q;
   logic [31:0]   srcAddr_q;
   logic [31:0]   dstAddr_q;
   logic [15:0]   len_q;
   logic [15:0]   idx_q;
   logic [CW-1:0] waitCnt_q;
   logic          busy_q;
   logic          done_q;
   logic          error_q;
   logic          cyc_q;
   logic          stb_q;
   logic          we_q;
   logic [3:0]    sel_q;
   logic [31:0]   adr_q;
   logic [31:0]   datMosi_q;

   logic [15:0]   idxInc_d;
   logic          timedOut_d;
   logic          abort_d;

   // A late ack on the last permitted wait cycle still counts; err always wins over ack.
   assign idxInc_d   = idx_q + 16'd1;
   assign timedOut_d = (waitCnt_q == WAIT_LAST) && !m.ack;
   assign abort_d    = m.err || timedOut_d;

   // datMosi_q doubles as the holding register for the word in flight between read and write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         srcAddr_q <= '0;
         dstAddr_q <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         waitCnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'h0;
         adr_q     <= '0;
         datMosi_q <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (len == 16'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     srcAddr_q <= src_addr;
                     dstAddr_q <= dst_addr;
                     len_q     <= len;
                     idx_q     <= '0;
                     waitCnt_q <= '0;
                     busy_q    <= 1'b1;
                     cyc_q     <= 1'b1;
                     stb_q     <= 1'b1;
                     we_q      <= 1'b0;
                     sel_q     <= 4'hF;
                     adr_q     <= src_addr;
                     state_q   <= RD_REQ;
                  end
               end
            end

            RD_REQ: begin
               stb_q     <= 1'b0;
               waitCnt_q <= '0;
               state_q   <= RD_WAIT;
            end

            RD_WAIT: begin
               if (abort_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  error_q <= 1'b1;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= 4'h0;
                  state_q <= IDLE;
               end else if (m.ack) begin
                  datMosi_q <= m.dat_miso;
                  stb_q     <= 1'b1;
                  we_q      <= 1'b1;
                  adr_q     <= dstAddr_q + {16'd0, idx_q};
                  state_q   <= WR_REQ;
               end else begin
                  waitCnt_q <= waitCnt_q + CW'(1);
               end
            end

            WR_REQ: begin
               stb_q     <= 1'b0;
               waitCnt_q <= '0;
               state_q   <= WR_WAIT;
            end

            WR_WAIT: begin
               if (abort_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  error_q <= 1'b1;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= 4'h0;
                  state_q <= IDLE;
               end else if (m.ack) begin
                  idx_q <= idxInc_d;
                  if (idxInc_d == len_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                     we_q    <= 1'b0;
                     sel_q   <= 4'h0;
                     state_q <= IDLE;
                  end else begin
                     stb_q   <= 1'b1;
                     we_q    <= 1'b0;
                     adr_q   <= srcAddr_q + {16'd0, idxInc_d};
                     state_q <= RD_REQ;
                  end
               end else begin
                  waitCnt_q <= waitCnt_q + CW'(1);
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign m.cyc      = cyc_q;
   assign m.stb      = stb_q;
   assign m.we       = we_q;
   assign m.sel      = sel_q;
   assign m.adr      = adr_q;
   assign m.dat_mosi = datMosi_q;

endmodule

// File: tb/tb_wishbone_dma.sv
// Directed bench for wishbone_dma: registered-ack memory slave, scoreboard of expected bus
// operations and completions, and checks on copy results, timing, errors, timeout and reset.
module tb_wishbone_dma;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } busOp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] srcAddr;
   logic [31:0] dstAddr;
   logic [15:0] len;
   logic        busy;
   logic        done;
   logic        error;

   wishbone_interface wb ();

   wishbone_dma #(.TIMEOUT(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .src_addr (srcAddr),
      .dst_addr (dstAddr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .m        (wb)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          busyCycles = 0;
   int          doneCount = 0;
   logic        cycSeen = 1'b0;
   logic        stall = 1'b0;
   logic        bdWe = 1'b0;
   logic [9:0]  bdAdr = '0;
   logic [31:0] bdDat = '0;
   logic [31:0] mem [0:1023];

   busOp_t expOps[$];
   logic   expDone[$];

   function automatic logic [31:0] b32(input logic b);
      return {31'd0, b};
   endfunction

   function automatic logic inRange(input logic [31:0] a);
      return (a < 32'h0000_0400) || (a >= 32'hFFFF_FC00);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"},     b32(busy),     32'd0);
      checkOutput({tag, "_done"},     b32(done),     32'd0);
      checkOutput({tag, "_error"},    b32(error),    32'd0);
      checkOutput({tag, "_cyc"},      b32(wb.cyc),   32'd0);
      checkOutput({tag, "_stb"},      b32(wb.stb),   32'd0);
      checkOutput({tag, "_we"},       b32(wb.we),    32'd0);
      checkOutput({tag, "_sel"},      {28'd0, wb.sel}, 32'd0);
      checkOutput({tag, "_adr"},      wb.adr,        32'd0);
      checkOutput({tag, "_dat_mosi"}, wb.dat_mosi,   32'd0);
   endtask

   task automatic pushOp(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      busOp_t op;
      op.we  = we;
      op.adr = adr;
      op.dat = dat;
      expOps.push_back(op);
   endtask

   task automatic memWrite(input logic [9:0] adr, input logic [31:0] dat);
      bdAdr = adr;
      bdDat = dat;
      bdWe  = 1'b1;
      @(negedge clk);
      bdWe  = 1'b0;
   endtask

   // Called just after a falling edge; returns one falling edge after the accepting rising edge.
   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      srcAddr    = s;
      dstAddr    = d;
      len        = n;
      busyCycles = 0;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int limit);
      logic got;
      got = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_done_seen"}, b32(got), 32'd1);
   endtask

   // Memory slave answering every strobe one cycle later, with err outside its address window.
   always @(posedge clk) begin
      if (bdWe) mem[bdAdr] <= bdDat;
      if (rst) begin
         wb.ack      <= 1'b0;
         wb.err      <= 1'b0;
         wb.dat_miso <= '0;
      end else begin
         wb.ack <= 1'b0;
         wb.err <= 1'b0;
         if (wb.cyc && wb.stb && !stall) begin
            if (inRange(wb.adr)) begin
               wb.ack <= 1'b1;
               if (wb.we) mem[wb.adr[9:0]] <= wb.dat_mosi;
               else       wb.dat_miso      <= mem[wb.adr[9:0]];
            end else begin
               wb.err <= 1'b1;
            end
         end
      end
   end

   // Scoreboard side: every strobe and every done pulse must match the next queued expectation.
   always @(negedge clk) begin
      busOp_t op;
      logic   expErr;
      if (busy) busyCycles++;
      if (wb.cyc) cycSeen = 1'b1;
      if (wb.cyc && wb.stb) begin
         checkOutput("strobe_expected", b32(expOps.size() != 0), 32'd1);
         if (expOps.size() != 0) begin
            op = expOps.pop_front();
            checkOutput("op_we",  b32(wb.we), b32(op.we));
            checkOutput("op_adr", wb.adr, op.adr);
            checkOutput("op_sel", {28'd0, wb.sel}, 32'h0000_000F);
            if (op.we) checkOutput("op_dat", wb.dat_mosi, op.dat);
         end
      end
      if (done) begin
         doneCount++;
         checkOutput("done_expected", b32(expDone.size() != 0), 32'd1);
         checkOutput("done_busy_low", b32(busy), 32'd0);
         if (expDone.size() != 0) begin
            expErr = expDone.pop_front();
            checkOutput("done_error", b32(error), b32(expErr));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time exceeded");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   doneBefore;
      int   wrSeen;
      int   waitCycles;
      logic found;

      rst     = 1'b1;
      start   = 1'b0;
      srcAddr = '0;
      dstAddr = '0;
      len     = '0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      rst = 1'b0;

      memWrite(10'h100, 32'hAAAA_0001);
      memWrite(10'h101, 32'hBBBB_0002);
      memWrite(10'h102, 32'hCCCC_0003);
      memWrite(10'h103, 32'hDDDD_0004);
      memWrite(10'h010, 32'h1111_0010);
      memWrite(10'h3FF, 32'h5A5A_FFFF);
      memWrite(10'h000, 32'hA5A5_0000);

      // Four-word copy, with a start pulse during the copy that must be ignored.
      pushOp(1'b0, 32'h100, '0); pushOp(1'b1, 32'h200, 32'hAAAA_0001);
      pushOp(1'b0, 32'h101, '0); pushOp(1'b1, 32'h201, 32'hBBBB_0002);
      pushOp(1'b0, 32'h102, '0); pushOp(1'b1, 32'h202, 32'hCCCC_0003);
      pushOp(1'b0, 32'h103, '0); pushOp(1'b1, 32'h203, 32'hDDDD_0004);
      expDone.push_back(1'b0);
      doneBefore = doneCount;
      applyStimulus(32'h100, 32'h200, 16'd4);
      repeat (2) @(negedge clk);
      srcAddr = 32'h300;
      dstAddr = 32'h310;
      len     = 16'd7;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      waitDone("copy4", 100);
      checkOutput("copy4_busy_cycles", busyCycles, 32'd16);
      checkOutput("copy4_error", b32(error), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("copy4_cyc_after", b32(wb.cyc), 32'd0);
      checkOutput("copy4_done_count", doneCount - doneBefore, 32'd1);
      checkOutput("copy4_mem0", mem[10'h200], 32'hAAAA_0001);
      checkOutput("copy4_mem1", mem[10'h201], 32'hBBBB_0002);
      checkOutput("copy4_mem2", mem[10'h202], 32'hCCCC_0003);
      checkOutput("copy4_mem3", mem[10'h203], 32'hDDDD_0004);

      // Zero-length request completes immediately without touching the bus.
      cycSeen = 1'b0;
      expDone.push_back(1'b0);
      applyStimulus(32'h40, 32'h50, 16'd0);
      checkOutput("len0_done", b32(done), 32'd1);
      checkOutput("len0_error", b32(error), 32'd0);
      checkOutput("len0_busy", b32(busy), 32'd0);
      @(negedge clk);
      checkOutput("len0_done_once", b32(done), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("len0_no_cyc", b32(cycSeen), 32'd0);

      // Destination outside the slave window: the first write draws err.
      pushOp(1'b0, 32'h10, '0);
      pushOp(1'b1, 32'h800, 32'h1111_0010);
      expDone.push_back(1'b1);
      applyStimulus(32'h10, 32'h800, 16'd2);
      waitDone("buserr", 100);
      checkOutput("buserr_error", b32(error), 32'd1);
      @(negedge clk);
      checkOutput("buserr_cyc_after", b32(wb.cyc), 32'd0);
      checkOutput("buserr_ops_left", expOps.size(), 32'd0);

      // Silent slave: abort after eight wait cycles.
      stall = 1'b1;
      pushOp(1'b0, 32'h20, '0);
      expDone.push_back(1'b1);
      applyStimulus(32'h20, 32'h600, 16'd1);
      checkOutput("timeout_strobe", b32(wb.stb), 32'd1);
      found      = 1'b0;
      waitCycles = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
         if (wb.cyc && !wb.stb) waitCycles++;
      end
      checkOutput("timeout_done_seen", b32(found), 32'd1);
      checkOutput("timeout_wait_cycles", waitCycles, 32'd8);
      checkOutput("timeout_error", b32(error), 32'd1);
      checkOutput("timeout_cyc", b32(wb.cyc), 32'd0);
      stall = 1'b0;
      @(negedge clk);

      // Source address wraps from 0xFFFFFFFF to 0.
      pushOp(1'b0, 32'hFFFF_FFFF, '0); pushOp(1'b1, 32'h300, 32'h5A5A_FFFF);
      pushOp(1'b0, 32'h0000_0000, '0); pushOp(1'b1, 32'h301, 32'hA5A5_0000);
      expDone.push_back(1'b0);
      applyStimulus(32'hFFFF_FFFF, 32'h300, 16'd2);
      waitDone("wrap", 100);
      checkOutput("wrap_busy_cycles", busyCycles, 32'd8);
      @(negedge clk);
      checkOutput("wrap_mem0", mem[10'h300], 32'h5A5A_FFFF);
      checkOutput("wrap_mem1", mem[10'h301], 32'hA5A5_0000);

      // Reset during the write wait of word 1 of a three-word copy.
      pushOp(1'b0, 32'h100, '0); pushOp(1'b1, 32'h340, 32'hAAAA_0001);
      pushOp(1'b0, 32'h101, '0); pushOp(1'b1, 32'h341, 32'hBBBB_0002);
      doneBefore = doneCount;
      applyStimulus(32'h100, 32'h340, 16'd3);
      found  = 1'b0;
      wrSeen = 0;
      for (int k = 0; k < 100; k++) begin
         if (wb.stb && wb.we) wrSeen++;
         if (wrSeen == 2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("rst_word1_write", b32(found), 32'd1);
      @(negedge clk);
      checkOutput("rst_in_wr_wait", b32(wb.cyc && wb.we && !wb.stb), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkIdle("midcopy_reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("rst_no_done", doneCount - doneBefore, 32'd0);
      checkOutput("rst_ops_left", expOps.size(), 32'd0);
      checkOutput("rst_word0_kept", mem[10'h340], 32'hAAAA_0001);

      // Normal copy right after the reset.
      pushOp(1'b0, 32'h100, '0); pushOp(1'b1, 32'h380, 32'hAAAA_0001);
      pushOp(1'b0, 32'h101, '0); pushOp(1'b1, 32'h381, 32'hBBBB_0002);
      pushOp(1'b0, 32'h102, '0); pushOp(1'b1, 32'h382, 32'hCCCC_0003);
      expDone.push_back(1'b0);
      applyStimulus(32'h100, 32'h380, 16'd3);
      waitDone("postrst", 100);
      checkOutput("postrst_busy_cycles", busyCycles, 32'd12);
      @(negedge clk);
      checkOutput("postrst_mem0", mem[10'h380], 32'hAAAA_0001);
      checkOutput("postrst_mem1", mem[10'h381], 32'hBBBB_0002);
      checkOutput("postrst_mem2", mem[10'h382], 32'hCCCC_0003);

      repeat (3) @(negedge clk);
      checkOutput("final_ops_left", expOps.size(), 32'd0);
      checkOutput("final_done_left", expDone.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wishbone_dma.md
WISHBONE_DMA -- requirements
Module: wishbone_dma

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the max cycles waited for ack/err after a request strobe before aborting.
REQ-002 Port: clk  input  1  clock, all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 Port: src_addr  input  32  source word address, latched on accepted start.
REQ-006 Port: dst_addr  input  32  destination word address, latched on accepted start.
REQ-007 Port: len  input  16  number of 32-bit words to copy, latched on accepted start.
REQ-008 Port: busy  output  1  high while a copy is in progress.
REQ-009 Port: done  output  1  one-cycle pulse at copy end, success or failure.
REQ-010 Port: error  output  1  one-cycle pulse with done when the copy aborted (bus err or timeout).
REQ-011 Port: m  wishbone_interface.master  --  bus master port; drives cyc, stb, we, adr[31:0], sel[3:0], dat_mosi[31:0]; samples ack, err, dat_miso[31:0].

Function
REQ-012 States SHALL be IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT; all outputs registered.
REQ-013 IDLE + start + len!=0 -> RD_REQ; busy=1 next cycle; word index i cleared to 0.
REQ-014 IDLE + start + len==0 -> stay IDLE; done=1 (error=0) next cycle; no bus activity.
REQ-015 start while busy SHALL be ignored; latched src/dst/len SHALL not change mid-copy.
REQ-016 RD_REQ: cyc=1, stb=1, we=0, sel=4'hF, adr=src+i for exactly one cycle, then RD_WAIT.
REQ-017 RD_WAIT: cyc=1, stb=0; on ack capture dat_miso into a 32-bit holding register, go WR_REQ.
REQ-018 WR_REQ: cyc=1, stb=1, we=1, sel=4'hF, adr=dst+i, dat_mosi=holding register for exactly one cycle, then WR_WAIT.
REQ-019 WR_WAIT: cyc=1, stb=0; on ack increment i; if i+1==len go IDLE with done=1, else go RD_REQ.
REQ-020 stb SHALL be high exactly one cycle per transfer so a registered-ack slave never sees a repeated request; cyc SHALL stay high from RD_REQ until the final ack/err.
REQ-021 Against a slave acking one cycle after stb, each word SHALL take 4 cycles; a len=N copy SHALL hold busy 4N cycles.
REQ-022 err in RD_WAIT/WR_WAIT SHALL drop cyc next cycle, go IDLE, pulse done=1 and error=1; the failing write (if any) is not retried.
REQ-023 A wait-cycle counter SHALL reset on each RD_REQ/WR_REQ; reaching TIMEOUT in a WAIT state SHALL abort as for err.
REQ-024 ack or err arriving outside a WAIT state SHALL be ignored; ack and err together SHALL be treated as err.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32 (src+i, dst+i wrap past 0xFFFFFFFF to 0).
REQ-026 busy SHALL fall in the same cycle done pulses; a new start is accepted in that cycle's successor at the earliest.
REQ-027 Overlapping src/dst ranges SHALL be copied strictly in ascending i with no hazard handling.

Reset
REQ-028 rst SHALL force IDLE and busy=0, done=0, error=0, cyc=0, stb=0, we=0, sel=0, adr=0, dat_mosi=0, i=0, timeout counter=0 on the next edge.
REQ-029 rst mid-copy SHALL abort without a done pulse; memory writes already acked remain, no further requests issue.

Verification
REQ-030 src=0x100, dst=0x200, len=4, memory[0x100..0x103]=A,B,C,D -> 0x200..0x203=A,B,C,D; busy high 16 cycles; one done, error=0.
REQ-031 len=0 start -> done=1 next cycle, error=0, cyc never asserted.
REQ-032 src in-range, dst out of slave range, len=2 -> first write gets err; done=1, error=1; exactly one read and one write issued; cyc low after.
REQ-033 Slave stalled (no ack/err), TIMEOUT=8 -> abort 8 cycles after RD_REQ strobe; done=1, error=1, cyc=0.
REQ-034 src=0xFFFFFFFF, len=2 -> reads at 0xFFFFFFFF then 0x00000000.
REQ-035 rst asserted during WR_WAIT of word 1 of len=3 -> all outputs 0 next cycle, no done pulse; start after reset runs normally; start pulsed while busy has no effect.
